// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the i2c_master_top request sequencer: core register map,
// CR/SR bit meanings, response status codes and the sequencer state encoding.
package i2c_seq_pkg;

    localparam logic [2:0] REG_PRERLO  = 3'd0;
    localparam logic [2:0] REG_PRERHI  = 3'd1;
    localparam logic [2:0] REG_CTR     = 3'd2;
    localparam logic [2:0] REG_TXR_RXR = 3'd3;
    localparam logic [2:0] REG_CR_SR   = 3'd4;

    localparam logic [7:0] CR_STA  = 8'h80;
    localparam logic [7:0] CR_STO  = 8'h40;
    localparam logic [7:0] CR_RD   = 8'h20;
    localparam logic [7:0] CR_WR   = 8'h10;
    localparam logic [7:0] CR_ACK  = 8'h08;
    localparam logic [7:0] CR_IACK = 8'h01;

    localparam logic [7:0] CTR_EN  = 8'h80;
    localparam logic [7:0] CTR_IEN = 8'h40;

    localparam int SR_RXACK = 7;
    localparam int SR_BUSY  = 6;
    localparam int SR_AL    = 5;
    localparam int SR_TIP   = 1;
    localparam int SR_IF    = 0;

    typedef enum logic [1:0] {
        STAT_OK         = 2'd0,
        STAT_NACK       = 2'd1,
        STAT_ARB_LOST   = 2'd2,
        STAT_WB_TIMEOUT = 2'd3
    } status_e;

    typedef enum logic [3:0] {
        ST_INIT_PRLO,
        ST_INIT_PRHI,
        ST_INIT_CTR,
        ST_IDLE,
        ST_TXR,
        ST_CR,
        ST_POLL,
        ST_STOP,
        ST_STOP_POLL,
        ST_RXR,
        ST_RESP
    } state_e;

    // Byte steps: 0 address(W), 1 register index, 2 write data or address(R), 3 read byte.
    function automatic logic [7:0] txr_byte(input logic [1:0] idx, input logic rnw,
                                            input logic [6:0] addr, input logic [7:0] rg,
                                            input logic [7:0] wdata);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {addr, 1'b0};
            2'd1:    b = rg;
            default: b = rnw ? {addr, 1'b1} : wdata;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] cr_byte(input logic [1:0] idx, input logic rnw);
        logic [7:0] b;
        case (idx)
            2'd0:    b = CR_STA | CR_WR;
            2'd1:    b = CR_WR;
            2'd2:    b = rnw ? (CR_STA | CR_WR) : (CR_STO | CR_WR);
            default: b = CR_RD | CR_ACK | CR_STO;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/i2c_seq_wb_port.sv
// Single Wishbone access engine: start launches one access, done pulses the cycle after
// ack (or after WB_TO ack-less cycles with timeout set); bus is idle for that done cycle.
module i2c_seq_wb_port #(
    parameter int WB_TO = 16
) (
    input  logic       core_clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] adr,
    input  logic [7:0] wdat,
    input  logic       we,
    output logic       done,
    output logic       timeout,
    output logic [7:0] rdata,
    output logic [2:0] wb_adr,
    output logic [7:0] wb_wdat,
    input  logic [7:0] wb_rdat,
    output logic       wb_we,
    output logic       wb_stb,
    output logic       wb_cyc,
    input  logic       wb_ack
);

    localparam logic [15:0] TO_LAST = 16'(WB_TO - 1);

    logic [15:0] wait_cnt;

    always_ff @(posedge core_clk) begin
        if (!rst_n) begin
            done     <= 1'b0;
            timeout  <= 1'b0;
            rdata    <= 8'h00;
            wb_adr   <= 3'd0;
            wb_wdat  <= 8'h00;
            wb_we    <= 1'b0;
            wb_stb   <= 1'b0;
            wb_cyc   <= 1'b0;
            wait_cnt <= 16'd0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            if (wb_cyc) begin
                if (wb_ack || wait_cnt == TO_LAST) begin
                    // All five bus signals return to zero so the bus reads idle between accesses.
                    wb_adr  <= 3'd0;
                    wb_wdat <= 8'h00;
                    wb_we   <= 1'b0;
                    wb_stb  <= 1'b0;
                    wb_cyc  <= 1'b0;
                    done    <= 1'b1;
                    timeout <= !wb_ack;
                    if (wb_ack) begin
                        rdata <= wb_rdat;
                    end
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
            end else if (start) begin
                wb_adr   <= adr;
                wb_wdat  <= wdat;
                wb_we    <= we;
                wb_stb   <= 1'b1;
                wb_cyc   <= 1'b1;
                wait_cnt <= 16'd0;
            end
        end
    end

endmodule

// File: rtl/i2c_wb_sequencer.sv
// Request/response front end for i2c_master_top: one register read/write per request, one
// response held until rsp_ready_i; requests arriving while busy are dropped. I2C_SEQ_IRQ_WAIT_EN.
module i2c_wb_sequencer
    import i2c_seq_pkg::*;
#(
    parameter logic [15:0] PRESCALE = 16'h0031,
    parameter int          WB_TO    = 16
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_n_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rnw_i,
    input  logic [6:0] req_addr_i,
    input  logic [7:0] req_reg_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_rdata_o,
    output logic [1:0] rsp_status_o,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    input  logic       wb_ack_i,
    input  logic       wb_inta_i
);

`ifdef I2C_SEQ_IRQ_WAIT_EN
    localparam logic [7:0] CTR_INIT = CTR_EN | CTR_IEN;
    localparam logic [7:0] CR_EXTRA = CR_IACK;
`else
    localparam logic [7:0] CTR_INIT = CTR_EN;
    localparam logic [7:0] CR_EXTRA = 8'h00;
`endif

    state_e     state;
    logic       pending;
    logic       acc_start;
    logic [2:0] acc_adr;
    logic [7:0] acc_dat;
    logic       acc_we;
    logic       acc_done;
    logic       acc_timeout;
    logic [7:0] acc_rdata;
    logic [2:0] cur_adr;
    logic [7:0] cur_dat;
    logic       cur_we;
    logic       cur_go;
    logic       poll_go;
    logic [1:0] byte_idx;
    logic       lat_rnw;
    logic [6:0] lat_addr;
    logic [7:0] lat_reg;
    logic [7:0] lat_wdata;
    logic       init_phase;
    logic       nack_stops;

`ifdef I2C_SEQ_IRQ_WAIT_EN
    assign poll_go = wb_inta_i;
`else
    // Back-to-back polling: the interrupt line has no influence on when SR is read.
    assign poll_go = wb_inta_i | 1'b1;
`endif

    assign init_phase = (state == ST_INIT_PRLO) || (state == ST_INIT_PRHI) || (state == ST_INIT_CTR);
    // Only address and register bytes need an explicit STOP after a NACK.
    assign nack_stops = (byte_idx < 2'd2) || (lat_rnw && byte_idx == 2'd2);

    always_comb begin
        cur_adr = REG_CR_SR;
        cur_dat = 8'h00;
        cur_we  = 1'b0;
        cur_go  = 1'b0;
        case (state)
            ST_INIT_PRLO: begin cur_adr = REG_PRERLO; cur_dat = PRESCALE[7:0];  cur_we = 1'b1; cur_go = 1'b1; end
            ST_INIT_PRHI: begin cur_adr = REG_PRERHI; cur_dat = PRESCALE[15:8]; cur_we = 1'b1; cur_go = 1'b1; end
            ST_INIT_CTR:  begin cur_adr = REG_CTR;    cur_dat = CTR_INIT;       cur_we = 1'b1; cur_go = 1'b1; end
            ST_TXR: begin
                cur_adr = REG_TXR_RXR;
                cur_dat = txr_byte(byte_idx, lat_rnw, lat_addr, lat_reg, lat_wdata);
                cur_we  = 1'b1;
                cur_go  = 1'b1;
            end
            ST_CR: begin
                cur_dat = cr_byte(byte_idx, lat_rnw) | CR_EXTRA;
                cur_we  = 1'b1;
                cur_go  = 1'b1;
            end
            ST_POLL:      cur_go = poll_go;
            ST_STOP:      begin cur_dat = CR_STO | CR_EXTRA; cur_we = 1'b1; cur_go = 1'b1; end
            ST_STOP_POLL: cur_go = 1'b1;
            ST_RXR:       begin cur_adr = REG_TXR_RXR; cur_go = 1'b1; end
            default:      cur_go = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state        <= ST_INIT_PRLO;
            pending      <= 1'b0;
            acc_start    <= 1'b0;
            acc_adr      <= 3'd0;
            acc_dat      <= 8'h00;
            acc_we       <= 1'b0;
            byte_idx     <= 2'd0;
            lat_rnw      <= 1'b0;
            lat_addr     <= 7'd0;
            lat_reg      <= 8'h00;
            lat_wdata    <= 8'h00;
            req_ready_o  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_rdata_o  <= 8'h00;
            rsp_status_o <= STAT_OK;
        end else begin
            acc_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        lat_rnw      <= req_rnw_i;
                        lat_addr     <= req_addr_i;
                        lat_reg      <= req_reg_i;
                        lat_wdata    <= req_wdata_i;
                        byte_idx     <= 2'd0;
                        rsp_rdata_o  <= 8'h00;
                        rsp_status_o <= STAT_OK;
                        req_ready_o  <= 1'b0;
                        state        <= ST_TXR;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    if (!pending) begin
                        if (cur_go) begin
                            acc_start <= 1'b1;
                            acc_adr   <= cur_adr;
                            acc_dat   <= cur_dat;
                            acc_we    <= cur_we;
                            pending   <= 1'b1;
                        end
                    end else if (acc_done) begin
                        pending <= 1'b0;
                        if (acc_timeout) begin
                            // A stuck core during init has no requester to report to; start over.
                            if (init_phase) begin
                                state <= ST_INIT_PRLO;
                            end else begin
                                rsp_status_o <= STAT_WB_TIMEOUT;
                                rsp_valid_o  <= 1'b1;
                                state        <= ST_RESP;
                            end
                        end else begin
                            case (state)
                                ST_INIT_PRLO: state <= ST_INIT_PRHI;
                                ST_INIT_PRHI: state <= ST_INIT_CTR;
                                ST_INIT_CTR: begin
                                    req_ready_o <= 1'b1;
                                    state       <= ST_IDLE;
                                end
                                ST_TXR: state <= ST_CR;
                                ST_CR:  state <= ST_POLL;
                                ST_POLL: begin
                                    if (acc_rdata[SR_TIP]) begin
                                        state <= ST_POLL;
                                    end else if (acc_rdata[SR_AL]) begin
                                        rsp_status_o <= STAT_ARB_LOST;
                                        rsp_valid_o  <= 1'b1;
                                        state        <= ST_RESP;
                                    end else if (acc_rdata[SR_RXACK] && nack_stops) begin
                                        state <= ST_STOP;
                                    end else if (byte_idx == 2'd3) begin
                                        state <= ST_RXR;
                                    end else if (byte_idx == 2'd2 && !lat_rnw) begin
                                        rsp_status_o <= acc_rdata[SR_RXACK] ? STAT_NACK : STAT_OK;
                                        rsp_valid_o  <= 1'b1;
                                        state        <= ST_RESP;
                                    end else if (byte_idx == 2'd2) begin
                                        byte_idx <= 2'd3;
                                        state    <= ST_CR;
                                    end else begin
                                        byte_idx <= byte_idx + 2'd1;
                                        state    <= ST_TXR;
                                    end
                                end
                                ST_STOP: state <= ST_STOP_POLL;
                                ST_STOP_POLL: begin
                                    if (!acc_rdata[SR_BUSY]) begin
                                        rsp_status_o <= STAT_NACK;
                                        rsp_valid_o  <= 1'b1;
                                        state        <= ST_RESP;
                                    end
                                end
                                ST_RXR: begin
                                    rsp_rdata_o  <= acc_rdata;
                                    rsp_status_o <= STAT_OK;
                                    rsp_valid_o  <= 1'b1;
                                    state        <= ST_RESP;
                                end
                                default: state <= state;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    i2c_seq_wb_port #(
        .WB_TO(WB_TO)
    ) u_wb_port (
        .core_clk(wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .start   (acc_start),
        .adr     (acc_adr),
        .wdat    (acc_dat),
        .we      (acc_we),
        .done    (acc_done),
        .timeout (acc_timeout),
        .rdata   (acc_rdata),
        .wb_adr  (wb_adr_o),
        .wb_wdat (wb_dat_o),
        .wb_rdat (wb_dat_i),
        .wb_we   (wb_we_o),
        .wb_stb  (wb_stb_o),
        .wb_cyc  (wb_cyc_o),
        .wb_ack  (wb_ack_i)
    );

endmodule

// File: doc/i2c_wb_sequencer.md
Name: i2c_wb_sequencer

Overview:
- Wishbone bus master that sits directly upstream of i2c_master_top, replacing hand-driven register pokes with a request/response interface.
- Accepts one register transfer request: 7-bit slave address, 8-bit register index, read or write.
- Programs prescaler and control at init, then issues the TXR/CR command sequence, polls SR and returns read data plus status.
- Drives wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o and wb_cyc_o into the core; samples wb_dat_i and wb_ack_i.

Parameters:
PRESCALE, 16'h0031, value written to PRERlo (addr 0) and PRERhi (addr 1) at init
WB_TO, 16, max cycles waiting for wb_ack_i per access before timeout abort

Ports:
wb_clk_i  in  1  single clock
wb_rst_n_i  in  1  synchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  sequencer idle and initialised
req_rnw_i  in  1  1=read, 0=write
req_addr_i  in  7  I2C slave address
req_reg_i  in  8  slave register index
req_wdata_i  in  8  write data
rsp_valid_o  out  1  response valid, held until accepted
rsp_ready_i  in  1  response accept
rsp_rdata_o  out  8  read data (0 for writes and errors)
rsp_status_o  out  2  0 OK, 1 NACK, 2 arbitration lost, 3 WB timeout
wb_adr_o  out  3  core register address
wb_dat_o  out  8  write data to core
wb_dat_i  in  8  read data from core
wb_we_o  out  1  write enable
wb_stb_o  out  1  strobe
wb_cyc_o  out  1  cycle valid
wb_ack_i  in  1  core acknowledge
wb_inta_i  in  1  core interrupt (used only with the optional feature)

Behaviour:
- Reset (wb_rst_n_i=0 at clock edge) clears all outputs to 0 and enters INIT; it aborts any in-flight access, including one with stb/cyc high.
- Wishbone access: cyc/stb/adr/dat/we are asserted together and held until the first cycle wb_ack_i=1.
  - All five are deasserted on the following cycle; there is a minimum of one idle cycle between accesses.
  - Read data is captured on the ack cycle.
  - If WB_TO cycles pass with no ack: drop cyc/stb, set status 3 and go to RESP. No STO is attempted.
- INIT: write addr0=PRESCALE[7:0], addr1=PRESCALE[15:8], addr2 (CTR)=8'h80, then IDLE. req_ready_o=1 only in IDLE.
- IDLE: on req_valid_i & req_ready_o, latch all request fields; req_ready_o drops the next cycle.
- Each byte step writes TXR (addr 3) then CR (addr 4), then enters POLL.
- POLL: read SR (addr 4) repeatedly until TIP (bit1)=0. Then check bits in this order:
  - AL (bit5)=1: status 2, go to RESP. No STO is sent, because the core releases the bus.
  - RxACK (bit7)=1 on an address or register byte: write CR=8'h40 (STO), poll until Busy (bit6)=0, status 1, go to RESP.
- Write sequence:
  - TXR={addr,0}, CR=8'h90
  - TXR=reg, CR=8'h10
  - TXR=wdata, CR=8'h50 (STO|WR)
  - A NACK on the data byte yields status 1 with no extra STO, because STO was already issued.
- Read sequence:
  - TXR={addr,0}, CR=8'h90
  - TXR=reg, CR=8'h10
  - TXR={addr,1}, CR=8'h90 (repeated start)
  - CR=8'h68 (RD|ACK=NACK|STO), poll
  - Read RXR (addr 3) into rsp_rdata_o.
- RESP: rsp_valid_o=1 with data/status stable until the cycle rsp_ready_i=1; go to IDLE the next cycle. Same-cycle request acceptance is not allowed.
- Requests with req_valid_i during non-IDLE are ignored (not queued).

Optional Feature:
- Macro: I2C_SEQ_IRQ_WAIT_EN.
- When defined:
  - INIT writes CTR=8'hC0 (EN|IEN).
  - POLL idles the bus until wb_inta_i=1, then does one SR read.
  - Each subsequent CR write includes IACK (bit0).
- When undefined: wb_inta_i is ignored and SR is polled back-to-back.

Decomposition:
- Shared package i2c_seq_pkg holds:
  - register addresses (PRERLO=0, PRERHI=1, CTR=2, TXR_RXR=3, CR_SR=4)
  - CR bit constants (STA, STO, RD, WR, ACK, IACK)
  - SR bit positions (RXACK, BUSY, AL, TIP, IF)
  - status codes
  - the state enum
- One natural sub-module, i2c_seq_wb_port: a single-access Wishbone engine with start/done/timeout, adr/dat/we in and rdata out. The top FSM sequences calls to it.

Test Plan:
- Reset, then init (bench ack latency 2 cycles): WB writes adr0=8'h31, adr1=8'h00, adr2=8'h80 in order; req_ready_o=1 afterwards.
- Write to slave 7'h2, reg 8'h05, data 8'hA5: WB writes in order TXR=8'h04, CR=8'h90, TXR=8'h05, CR=8'h10, TXR=8'hA5, CR=8'h50, with SR polls between; rsp_status_o=0.
- Read slave 7'h2 reg 8'h05: CR=8'h90 issued twice (second with TXR=8'h05 from {addr,1}), then CR=8'h68; rsp_rdata_o=8'hA5, status 0.
- Write to absent slave 7'h7: after the first poll RxACK=1, CR=8'h40 written; rsp_status_o=1; the next request is accepted normally.
- Bench never acks: cyc/stb drop after exactly 16 cycles; rsp_status_o=3. Hold rsp_ready_i=0 for 10 cycles: rsp_valid_o and data stay stable.
- Assert wb_rst_n_i low during the read's SR poll: all outputs 0 the next cycle; init sequence re-runs on release.
